// File: rtl/shift_add_mult_ctrl.sv
// Sequential 4x4 unsigned shift-add multiplier: one 4-bit ripple adder reused over
// four iterations, with a start strobe, busy flag, one-cycle done pulse and held product.
module shift_add_mult_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      r_state;
  logic [3:0]  r_m;
  logic [3:0]  r_a;
  logic [3:0]  r_q;
  logic [1:0]  r_count;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_product;

  logic [3:0]  w_addend;
  logic [3:0]  w_sum;
  logic [4:0]  w_carry;
  logic        w_cout;
  logic [3:0]  w_a_next;
  logic [3:0]  w_q_next;

  // Shared 4-bit ripple adder (no carry-in); its carry-out is the only overflow bit.
  always_comb begin
    w_addend   = r_q[0] ? r_m : 4'h0;
    w_carry    = '0;
    w_sum      = '0;
    for (int i = 0; i < 4; i++) begin
      w_sum[i]       = r_a[i] ^ w_addend[i] ^ w_carry[i];
      w_carry[i + 1] = (r_a[i] & w_addend[i]) | (w_carry[i] & (r_a[i] ^ w_addend[i]));
    end
    w_cout = w_carry[4];
  end

  // {C,A,Q} <= {cout,sum,Q} >> 1; C always ends up zero, so it is not stored separately.
  assign w_a_next = {w_cout, w_sum[3:1]};
  assign w_q_next = {w_sum[0], r_q[3:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_a     <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= StCalc;
          end
        end
        StCalc: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_count <= r_count + 2'd1;
          if (r_count == 2'd3) begin
            r_product <= {w_a_next, w_q_next};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl: table of operand/product vectors with exact
// cycle-timing checks, plus sequences for held start, mid-operation start and async reset.
module tb_shift_add_mult_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_tests;
  int n_fail;

  shift_add_mult_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Start at a negedge in IDLE, then check busy for 4 cycles, done in the 5th, idle after.
  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 4'hx;
    multiplier   = 4'hx;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("busy_c%0d_%0dx%0d", k, m, q), {7'd0, busy}, 8'd1);
      check($sformatf("nodone_c%0d_%0dx%0d", k, m, q), {7'd0, done}, 8'd0);
      @(negedge clk);
    end
    check($sformatf("busy_c4_%0dx%0d", m, q), {7'd0, busy}, 8'd1);
    @(negedge clk);
    check($sformatf("done_%0dx%0d", m, q), {7'd0, done}, 8'd1);
    check($sformatf("busy_off_%0dx%0d", m, q), {7'd0, busy}, 8'd0);
    check($sformatf("product_%0dx%0d", m, q), product, exp);
    @(negedge clk);
    check($sformatf("done_pulse_%0dx%0d", m, q), {7'd0, done}, 8'd0);
    check($sformatf("product_hold_%0dx%0d", m, q), product, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{m: 4'd13, q: 4'd11, exp: 8'h8F};
    vecs[1] = '{m: 4'd15, q: 4'd15, exp: 8'hE1};
    vecs[2] = '{m: 4'd0,  q: 4'd9,  exp: 8'h00};
    vecs[3] = '{m: 4'd9,  q: 4'd0,  exp: 8'h00};
    vecs[4] = '{m: 4'd1,  q: 4'd1,  exp: 8'h01};
    vecs[5] = '{m: 4'd15, q: 4'd1,  exp: 8'h0F};
    vecs[6] = '{m: 4'd1,  q: 4'd15, exp: 8'h0F};
    vecs[7] = '{m: 4'd8,  q: 4'd8,  exp: 8'h40};

    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = 4'h0;
    multiplier   = 4'h0;
    repeat (2) @(negedge clk);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_done", {7'd0, done}, 8'd0);
    check("reset_product", product, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {7'd0, busy}, 8'd0);

    foreach (vecs[i]) run_op(vecs[i].m, vecs[i].q, vecs[i].exp);

    // start held high: accepted at edges 0 and 6, done seen after edges 4 and 10
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 4'd3;
    multiplier   = 4'd5;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("held_done_e%0d", k), {7'd0, done}, (k == 4 || k == 10) ? 8'd1 : 8'd0);
      check($sformatf("held_busy_e%0d", k), {7'd0, busy},
            ((k < 4) || (k >= 6 && k < 10)) ? 8'd1 : 8'd0);
      if (k == 4 || k == 10) check($sformatf("held_product_e%0d", k), product, 8'h0F);
    end
    start = 1'b0;
    @(negedge clk);
    check("held_back_idle", {7'd0, busy}, 8'd0);

    // new operands and start pulse during CALC must be ignored
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 4'd7;
    multiplier   = 4'd6;
    @(negedge clk);
    multiplicand = 4'd15;
    multiplier   = 4'd15;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midstart_busy_c4", {7'd0, busy}, 8'd1);
    @(negedge clk);
    check("midstart_done", {7'd0, done}, 8'd1);
    check("midstart_product", product, 8'h2A);
    @(negedge clk);
    check("midstart_no_second", {7'd0, done}, 8'd0);
    @(negedge clk);
    check("midstart_idle", {7'd0, busy}, 8'd0);

    // async reset in the 2nd CALC cycle aborts with no done
    run_op(4'd2, 4'd3, 8'h06);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 4'd12;
    multiplier   = 4'd12;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_pre_busy", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_done", {7'd0, done}, 8'd0);
    check("abort_product", product, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_done_%0d", k), {7'd0, done}, 8'd0);
      check($sformatf("post_reset_busy_%0d", k), {7'd0, busy}, 8'd0);
    end
    check("post_reset_product", product, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
